// File: rtl/requant_pipe.sv
// Two-stage requantiser: per-lane round+arithmetic-shift, then clamp to OUT_W signed/ReLU range.
// Optional saturated-lane counter (sat_cnt, sat_cnt_clr) enabled by defining QUANT_SAT_CNT_EN.
module requant_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     cfg_we,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_relu,
    output logic                     cfg_rej,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data
`ifdef QUANT_SAT_CNT_EN
    ,
    input  logic                     sat_cnt_clr,
    output logic [15:0]              sat_cnt
`endif
);

    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] HI = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] LO = ~HI;

    logic [1:0]             rst_sync;
    logic                   rstn_i;
    logic [SHIFT_W-1:0]     shift_q;
    logic                   relu_q;
    logic [SHIFT_W-1:0]     shift_eff;
    logic                   s1_valid;
    logic                   s1_relu;
    logic [LANES*RW-1:0]    s1_data;
    logic                   s2_valid;
    logic                   accept;
    logic                   s2_load;
    logic                   cfg_ok;
    logic signed [RW-1:0]   bias;
    logic [LANES*RW-1:0]    rnd_data;
    logic [LANES*OUT_W-1:0] clamp_data;
`ifdef QUANT_SAT_CNT_EN
    logic [LANES-1:0]       lane_sat;
    logic [16:0]            sat_sum;
`endif

    // Assertion is immediate; deassertion reaches the core two clocks later.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rstn_i = rst_sync[1];

    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign cfg_ok    = !s1_valid && !s2_valid && !in_valid;
    assign out_valid = s2_valid;

    always_comb begin
        if (int'(cfg_shift) >= IN_W) shift_eff = SHIFT_W'(IN_W - 1);
        else                         shift_eff = cfg_shift;
    end

    always_comb begin
        if (shift_q == '0) bias = '0;
        else               bias = RW'(1) << (shift_q - SHIFT_W'(1));
    end

    always_comb begin
        logic signed [RW-1:0] x;
        x        = '0;
        rnd_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            x = {in_data[i*IN_W + IN_W - 1], in_data[i*IN_W +: IN_W]};
            rnd_data[i*RW +: RW] = (x + bias) >>> shift_q;
        end
    end

    always_comb begin
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] lo;
        r          = '0;
        lo         = s1_relu ? '0 : LO;
        clamp_data = '0;
`ifdef QUANT_SAT_CNT_EN
        lane_sat   = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            r = s1_data[i*RW +: RW];
            if (r > HI) begin
                clamp_data[i*OUT_W +: OUT_W] = HI[OUT_W-1:0];
`ifdef QUANT_SAT_CNT_EN
                lane_sat[i] = 1'b1;
`endif
            end else if (r < lo) begin
                clamp_data[i*OUT_W +: OUT_W] = lo[OUT_W-1:0];
`ifdef QUANT_SAT_CNT_EN
                lane_sat[i] = 1'b1;
`endif
            end else begin
                clamp_data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
            end
        end
    end

    // S1 keeps the relu flag of its own beat so a later config never reinterprets it.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_relu  <= 1'b1;
            s2_valid <= 1'b0;
            out_data <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= rnd_data;
                s1_relu  <= relu_q;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
                out_data <= clamp_data;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            shift_q <= SHIFT_W'(6);
            relu_q  <= 1'b1;
            cfg_rej <= 1'b0;
        end else begin
            cfg_rej <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                shift_q <= shift_eff;
                relu_q  <= cfg_relu;
            end
        end
    end

`ifdef QUANT_SAT_CNT_EN
    assign sat_sum = {1'b0, sat_cnt} + 17'($countones(lane_sat));

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)          sat_cnt <= '0;
        else if (sat_cnt_clr) sat_cnt <= '0;
        else if (s2_load)     sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_requant_pipe.sv
// Scoreboard bench for requant_pipe: driver pushes model results, monitor pops on each output handshake.
// Counter checks are compiled in when QUANT_SAT_CNT_EN is defined.
module tb_requant_pipe;

    localparam int IN_W    = 32;
    localparam int OUT_W   = 8;
    localparam int LANES   = 4;
    localparam int SHIFT_W = 5;

    logic                   clk;
    logic                   srstn;
    logic                   cfg_we;
    logic [SHIFT_W-1:0]     cfg_shift;
    logic                   cfg_relu;
    logic                   cfg_rej;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
`ifdef QUANT_SAT_CNT_EN
    logic                   sat_cnt_clr;
    logic [15:0]            sat_cnt;
`endif

    requant_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .srstn(srstn),
        .cfg_we(cfg_we), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_rej(cfg_rej),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef QUANT_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int tb_shift = 6;
    bit tb_relu  = 1'b1;
    int rdy_mode = 1;
    logic [LANES*OUT_W-1:0] expq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference: floor((x + half) / 2^sh), then saturate to the output range.
    function automatic logic [OUT_W-1:0] model_lane(input longint x, input int sh, input bit relu);
        longint d, v, q, hi, lo;
        d  = longint'(1) << sh;
        v  = x + ((sh == 0) ? 0 : d / 2);
        q  = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        hi = (2 ** (OUT_W - 1)) - 1;
        lo = relu ? 0 : -(2 ** (OUT_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q[OUT_W-1:0];
    endfunction

    function automatic logic [LANES*OUT_W-1:0] model_beat(input logic [LANES*IN_W-1:0] d,
                                                          input int sh, input bit relu);
        logic [LANES*OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*OUT_W +: OUT_W] = model_lane(longint'($signed(d[i*IN_W +: IN_W])), sh, relu);
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return IN_W'($urandom);
            1:       return IN_W'(int'($urandom_range(0, 8191)) - 4096);
            2:       return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return IN_W'($signed($urandom) >>> $urandom_range(0, 31));
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops one expected beat per output handshake and checks stall stability.
    logic [LANES*OUT_W-1:0] held;
    bit stall = 1'b0;
    always @(negedge clk) begin
        logic [LANES*OUT_W-1:0] e;
        if (!srstn) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: actual %0h required none", out_data);
                end else begin
                    e = expq.pop_front();
                    check("out_data", 64'(out_data), 64'(e));
                    n_out++;
                end
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
    end

    task automatic send(input logic [LANES*IN_W-1:0] d, input bit use_exp,
                        input logic [LANES*OUT_W-1:0] ex);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        else expq.push_back(use_exp ? ex : model_beat(d, tb_shift, tb_relu));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(expq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int sh, input bit relu);
        bit ok;
        ok        = (expq.size() == 0) && !in_valid;
        cfg_we    = 1'b1;
        cfg_shift = SHIFT_W'(sh);
        cfg_relu  = relu;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (ok) begin
            tb_shift = (sh >= IN_W) ? IN_W - 1 : sh;
            tb_relu  = relu;
        end
        @(negedge clk);
        check("cfg_rej", 64'(cfg_rej), 64'(!ok));
        @(posedge clk);
        @(negedge clk);
        check("cfg_rej_pulse", 64'(cfg_rej), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*IN_W-1:0] d;
        int base, t, seen;
        srstn = 1'b0; cfg_we = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef QUANT_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 srstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_cfg_rej", 64'(cfg_rej), 64'd0);
        idle(3);

        // Reset defaults shift=6 relu=1, with exact two-cycle latency.
        d = {32'hFFFF_FFD8, 32'd8160, 32'd96, 32'd95};
        send(d, 1'b1, {8'd0, 8'd127, 8'd2, 8'd1});
        @(negedge clk);
        check("lat_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_s2", 64'(out_valid), 64'd1);
        drain();

        do_cfg(5, 1'b0);
`ifdef QUANT_SAT_CNT_EN
        sat_cnt_clr = 1'b1;
        idle(1);
        sat_cnt_clr = 1'b0;
`endif
        d = {32'd15, 32'h7FFF_FFFF, 32'hFFFF_EFEF, 32'hFFFF_EFF0};
        send(d, 1'b1, {8'h00, 8'h7F, 8'h80, 8'h80});
        drain();
`ifdef QUANT_SAT_CNT_EN
        check("sat_cnt_two", 64'(sat_cnt), 64'd2);
`endif

        // Config write refused while S2 is stalled; in-flight and later beats keep shift=5.
        rdy_mode = 0;
        idle(1);
        send({4{32'd100}}, 1'b0, '0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        do_cfg(3, 1'b1);
        rdy_mode = 1;
        drain();
        send({32'hFFFF_FC18, 32'd1000, 32'd100, 32'hFFFF_FF9C}, 1'b0, '0);
        drain();
        do_cfg(3, 1'b1);
        send({32'hFFFF_FC18, 32'd1000, 32'd100, 32'hFFFF_FF9C}, 1'b0, '0);
        drain();

        // Random traffic: 100 beats, random in_valid gaps and out_ready.
        base = n_out;
        for (int c = 0; c < 2; c++) begin
            rdy_mode = 1;
            drain();
            do_cfg((c == 0) ? 0 : int'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
            rdy_mode = 2;
            for (int b = 0; b < 50; b++) begin
                while ($urandom_range(0, 1) == 1) idle(1);
                for (int l = 0; l < LANES; l++) d[l*IN_W +: IN_W] = rand_lane();
                send(d, 1'b0, '0);
            end
        end
        drain();
        check("beat_count", 64'(n_out - base), 64'd100);

        // Reset with two beats in flight.
        rdy_mode = 0;
        idle(1);
        send({4{32'd7}}, 1'b0, '0);
        send({4{32'd9}}, 1'b0, '0);
        srstn = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        expq.delete();
        idle(2);
        srstn = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_beat", 64'(seen), 64'd0);
        idle(1);
        tb_shift = 6;
        tb_relu  = 1'b1;
        send({32'hFFFF_FFD8, 32'd8160, 32'd96, 32'd95}, 1'b1, {8'd0, 8'd127, 8'd2, 8'd1});
        drain();

`ifdef QUANT_SAT_CNT_EN
        do_cfg(5, 1'b0);
        sat_cnt_clr = 1'b1;
        idle(1);
        sat_cnt_clr = 1'b0;
        repeat (16383) send({4{32'h7FFF_FFFF}}, 1'b0, '0);
        send({32'd15, 32'h7FFF_FFFF, 32'hFFFF_EFEF, 32'hFFFF_EFF0}, 1'b0, '0);
        drain();
        check("sat_cnt_fffe", 64'(sat_cnt), 64'hFFFE);
        send({4{32'h7FFF_FFFF}}, 1'b0, '0);
        drain();
        check("sat_cnt_fffe_plus4", 64'(sat_cnt), 64'hFFFF);
        sat_cnt_clr = 1'b1;
        send({4{32'h7FFF_FFFF}}, 1'b0, '0);
        drain();
        sat_cnt_clr = 1'b0;
        check("sat_cnt_clr_wins", 64'(sat_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/requant_pipe.md
REQUANT_PIPE -- requirements
Module: requant_pipe

Interface
REQ-001 SHALL have parameters: IN_W, default 32, accumulator width; OUT_W, default 8, output width; LANES, default 4, parallel channels; SHIFT_W, default 5, shift field width.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; srstn  input  1  async active-low reset.
REQ-003 SHALL have config ports: cfg_we  input  1  load config; cfg_shift  input  SHIFT_W  right-shift amount; cfg_relu  input  1  1=clamp [0,max], 0=signed clamp; cfg_rej  output  1  one-cycle pulse, write refused.
REQ-004 SHALL have input stream: in_valid  input  1; in_ready  output  1; in_data  input  LANES*IN_W  signed lanes, lane 0 in LSBs.
REQ-005 SHALL have output stream: out_valid  output  1; out_ready  input  1; out_data  output  LANES*OUT_W  signed lanes, lane 0 in LSBs.
REQ-006 SHALL have, when QUANT_SAT_CNT_EN is defined: sat_cnt_clr  input  1  synchronous clear; sat_cnt  output  16  saturated-lane count.

Function
REQ-007 SHALL be a 2-stage pipeline: S1 = round+shift register, S2 = clamp/output register; latency exactly 2 cycles from accepted input to out_valid with out_ready held high.
REQ-008 SHALL accept input on in_valid&&in_ready and emit output on out_valid&&out_ready; out_data/out_valid SHALL be held stable while out_valid&&!out_ready.
REQ-009 SHALL drive in_ready = !S1_valid || !S2_valid || out_ready (combinational, no in_valid dependence); sustained throughput one beat per cycle.
REQ-010 SHALL never drop or duplicate a beat under any in_valid/out_ready pattern; S2 loads from S1 whenever S2 is empty or being drained.
REQ-011 SHALL compute per lane r = (x + 2^(shift-1)) >>> shift in IN_W+1 bits (round half toward +inf); shift=0 SHALL add nothing.
REQ-012 SHALL clamp r to [0, 2^(OUT_W-1)-1] when relu=1, else [-2^(OUT_W-1), 2^(OUT_W-1)-1]; lanes independent.
REQ-013 SHALL hold active shift/relu in internal registers; cfg_we SHALL load them only when S1, S2 empty and in_valid low that cycle.
REQ-014 SHALL ignore cfg_we otherwise, keep old config, and assert cfg_rej for exactly the next cycle.
REQ-015 SHALL process a beat with the config active on the cycle it is accepted; beats in flight are never reinterpreted.
REQ-016 SHALL treat cfg_shift >= IN_W as IN_W-1.

Reset
REQ-017 SHALL on srstn low asynchronously clear S1/S2 valids, out_valid=0, out_data=0, cfg_rej=0, shift=6, relu=1, sat_cnt=0.
REQ-018 SHALL, when reset asserts mid-stream, discard in-flight beats; in_ready SHALL be 1 the first cycle after release.
REQ-019 SHALL release reset synchronously to clk (deassertion registered internally through a 2-flop synchroniser).

Configuration
REQ-020 SHALL with QUANT_SAT_CNT_EN defined add sat_cnt: on each S2 load, increment by the number of lanes clamped; saturate at 0xFFFF; sat_cnt_clr wins over a same-cycle increment.
REQ-021 SHALL without QUANT_SAT_CNT_EN omit sat_cnt and sat_cnt_clr ports and all counter logic; datapath behaviour identical.

Verification
REQ-022 SHALL pass: reset defaults (shift=6, relu=1), lanes {95,96,8160,-40} -> out_data lanes {1,2,127,0} two cycles later.
REQ-023 SHALL pass: cfg shift=5, relu=0, lanes {-4112,-4113,0x7FFFFFFF,15} -> {-128,-128,127,0}; with QUANT_SAT_CNT_EN sat_cnt=2.
REQ-024 SHALL pass: 100 random beats, in_valid and out_ready each random 50% -> outputs match model in order, count 100, no holds violated.
REQ-025 SHALL pass: cfg_we while S2 full and out_ready=0 -> cfg_rej=1 next cycle, shift unchanged; retry when idle -> accepted, cfg_rej=0.
REQ-026 SHALL pass: srstn pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat after release.
REQ-027 SHALL pass (QUANT_SAT_CNT_EN): sat_cnt preset to 0xFFFE, beat with 4 clamped lanes -> 0xFFFF; sat_cnt_clr concurrent with a clamped beat -> 0.
